// File: rtl/mem_if_pkg.sv
// Memory-interface encodings shared by every block that talks to the Mem4K memory.
package mem_if_pkg;

  // Read/write enable pair driven on mem_EnWR
  localparam logic       MM_ENB_R     = 1'b0;
  localparam logic       MM_ENB_W     = 1'b1;

  // Access-width code driven on mem_Size for a full 32-bit word
  localparam logic [1:0] MM_SIZE_WORD = 2'b11;

endpackage : mem_if_pkg

// File: rtl/mem_dump_reader.sv
// Reads a run of 32-bit words from the memory window and hands them out one at a
// time over a valid/ready port, stalling the memory side while the consumer waits.
module mem_dump_reader
  import mem_if_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [10:0] word_cnt,
  output logic        mem_EnWR,
  output logic [1:0]  mem_Size,
  output logic [31:0] mem_ABus,
  input  logic [31:0] mem_DBusR,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned STATE_W = 3;

  localparam logic [ADDR_W-1:0] MEM_SPAN = ADDR_W'(MEM_BYTES);

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] S_HOLD = 3'd3;
  localparam logic [STATE_W-1:0] S_FIN  = 3'd4;

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  mem_abus_q, mem_abus_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Reads only, always full words
  assign mem_EnWR  = MM_ENB_R;
  assign mem_Size  = MM_SIZE_WORD;
  assign mem_ABus  = mem_abus_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // State, walk pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_abus_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      mem_abus_q  <= mem_abus_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state plus the address/remaining-count walk
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            state_d = S_ADDR;
            addr_d  = (base_addr & ~ADDR_W'(3)) % MEM_SPAN;
            rem_d   = word_cnt;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = S_FIN;
            rem_d   = '0;
          end else begin
            state_d = S_ADDR;
            addr_d  = (addr_q + ADDR_W'(4)) % MEM_SPAN;
            rem_d   = rem_q - CNT_W'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register inputs, decoded from the state being entered
  always_comb begin
    out_valid_d = (state_d == S_HOLD);
    out_last_d  = (state_d == S_HOLD) && (rem_d == CNT_W'(1));
    done_d      = (state_d == S_FIN);
    busy_d      = (state_d != S_IDLE);
    mem_abus_d  = '0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if ((state_d == S_ADDR) || (state_d == S_WAIT) || (state_d == S_HOLD)) begin
      mem_abus_d = addr_d;
    end
    // Memory data for the address presented in ADDR is valid during WAIT
    if (state_q == S_WAIT) begin
      out_data_d = mem_DBusR;
      out_addr_d = addr_q;
    end
  end

endmodule : mem_dump_reader

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a one-cycle-latency word memory model.
module tb_mem_dump_reader;
  import mem_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [10:0] word_cnt;
  logic        mem_EnWR;
  logic [1:0]  mem_Size;
  logic [31:0] mem_ABus;
  logic [31:0] mem_DBusR;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;

  mem_dump_reader #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .mem_EnWR(mem_EnWR), .mem_Size(mem_Size), .mem_ABus(mem_ABus), .mem_DBusR(mem_DBusR),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address seen at an edge appears after it
  always @(posedge clk) mem_DBusR <= mem[mem_ABus[11:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic v, input logic l, input logic d,
                     input logic b, input logic [31:0] a);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".done"},  32'(done),      32'(d));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".abus"},  mem_ABus,       a);
  endtask

  task automatic word(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic l);
    ctl(tag, 1'b1, l, 1'b0, 1'b1, a);
    chk({tag, ".addr"}, out_addr, a);
    chk({tag, ".data"}, out_data, d);
  endtask

  task automatic kick(input logic [31:0] b, input logic [10:0] n);
    base_addr = b;
    word_cnt  = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    mem[10'h200] = 32'h00000013;
    mem[10'h201] = 32'h00008067;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0; out_ready = 1'b1;

    #3;
    ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.out_data", out_data, 32'h0);
    chk("reset.out_addr", out_addr, 32'h0);
    chk("enwr", 32'(mem_EnWR), 32'(MM_ENB_R));
    chk("size", 32'(mem_Size), 32'(MM_SIZE_WORD));
    tick(); tick();
    rst = 1'b0;
    tick();
    ctl("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Two-word dump, consumer always ready
    kick(32'h800, 11'd2);
    ctl("t1.addr0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
    tick(); ctl("t1.wait0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
    tick(); word("t1.hold0", 32'h800, 32'h00000013, 1'b0);
    tick(); ctl("t1.addr1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h804);
    tick(); ctl("t1.wait1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h804);
    tick(); word("t1.hold1", 32'h804, 32'h00008067, 1'b1);
    tick(); ctl("t1.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick(); ctl("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Same dump, consumer stalls the first word for 5 cycles
    out_ready = 1'b0;
    kick(32'h800, 11'd2);
    tick(); tick();
    word("t2.hold0", 32'h800, 32'h00000013, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); word("t2.stall", 32'h800, 32'h00000013, 1'b0);
    end
    tick(); out_ready = 1'b1;
    word("t2.release", 32'h800, 32'h00000013, 1'b0);
    tick(); ctl("t2.addr1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h804);
    tick(); tick(); word("t2.hold1", 32'h804, 32'h00008067, 1'b1);
    tick(); ctl("t2.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick(); ctl("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Unaligned base at the top of the window wraps to 0
    kick(32'hFFE, 11'd2);
    ctl("t3.addr0", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFC);
    tick(); tick(); word("t3.hold0", 32'hFFC, 32'hC0DE03FF, 1'b0);
    tick(); ctl("t3.addr1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h000);
    tick(); tick(); word("t3.hold1", 32'h000, 32'hC0DE0000, 1'b1);
    tick(); ctl("t3.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();

    // Zero-length dump
    kick(32'h400, 11'd0);
    ctl("t4.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick(); ctl("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset during WAIT of word 3 of 8, then a fresh single-word dump
    kick(32'h100, 11'd8);
    for (int i = 0; i < 7; i++) tick();
    ctl("t5.wait2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h108);
    rst = 1'b1;
    #1;
    ctl("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5.rst.out_data", out_data, 32'h0);
    chk("t5.rst.out_addr", out_addr, 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    ctl("t5.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    kick(32'h900, 11'd1);
    ctl("t5.addr", 1'b0, 1'b0, 1'b0, 1'b1, 32'h900);
    tick(); tick(); word("t5.hold", 32'h900, 32'hC0DE0240, 1'b1);
    tick(); ctl("t5.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick();

    // Start while busy is ignored
    kick(32'h200, 11'd2);
    base_addr = 32'h400; word_cnt = 11'd5; start = 1'b1;
    tick(); start = 1'b0;
    ctl("t6.wait0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    tick(); word("t6.hold0", 32'h200, 32'hC0DE0080, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    ctl("t6.addr1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h204);
    tick(); tick(); word("t6.hold1", 32'h204, 32'hC0DE0081, 1'b1);
    tick(); ctl("t6.fin", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    tick(); ctl("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); ctl("t6.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_dump_reader
